// File: rtl/proto_matrix_sequencer.sv
// -----------------------------------------------------------------------------
// proto_matrix_sequencer
//
// Walks the QC-LDPC prototype parity matrix, row by row and column by column,
// and hands one block command per circulant to the shift/accumulate datapath.
// The prototype matrix lives in an external ROM with a combinational read.
// Each ROM word is either a cyclic shift in 0..Z-1 or the all-ones null code.
// Null blocks can optionally be dropped, except in the last column. That way
// every row still closes with an end-of-row beat.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a scan (only honoured while idle)
//   abort      synchronous cancel, highest priority
//   busy       scan in progress (cycle after start .. done pulse)
//   done       one-cycle pulse after the last beat is accepted
//   err        sticky illegal-entry flag, cleared by the next accepted start
//   rom_addr   registered ROM address, row*COLS+col
//   rom_data   combinational ROM read of rom_addr
//   out_valid  command valid
//   out_ready  downstream accept
//   out_row    block row
//   out_col    block column
//   out_shift  cyclic shift (0 for null blocks)
//   out_null   block is a zero circulant
//   out_eor    last column of the row
//   out_last   last block of the matrix
// -----------------------------------------------------------------------------
module proto_matrix_sequencer #(
  parameter int Z         = 54,
  parameter int ROWS      = 4,
  parameter int COLS      = 24,
  parameter int SHIFTW    = $clog2(Z),
  parameter bit SKIP_NULL = 1'b1,
  localparam int AW       = $clog2(ROWS * COLS),
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     rom_addr,
  input  logic [SHIFTW-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic [SHIFTW-1:0] out_shift,
  output logic              out_null,
  output logic              out_eor,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  localparam logic [SHIFTW-1:0] NULL_CODE = '1;
  // When Z reaches the null code there is no code left that can be illegal.
  localparam bit              NO_ILLEGAL = (Z >= (1 << SHIFTW) - 1);
  localparam logic [SHIFTW-1:0] Z_CODE   = NO_ILLEGAL ? '1 : SHIFTW'(Z);
  localparam logic [RW-1:0]   ROW_MAX    = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_MAX    = CW'(COLS - 1);

  state_t          state_reg;
  logic [RW-1:0]   row_reg;
  logic [CW-1:0]   col_reg;

  // Entry classification of the word currently presented by the ROM.
  logic entry_is_null_code;
  logic entry_illegal;
  logic entry_null;
  logic at_eor;
  logic at_end;
  logic out_free;
  logic emit_entry;

  always_comb begin
    entry_is_null_code = (rom_data == NULL_CODE);
    entry_illegal      = !NO_ILLEGAL && !entry_is_null_code && (rom_data >= Z_CODE);
    // Illegal shifts are demoted to null blocks so the datapath never sees them.
    entry_null         = entry_is_null_code || entry_illegal;
    at_eor             = (col_reg == COL_MAX);
    at_end             = at_eor && (row_reg == ROW_MAX);
    // The output register can take a new entry when it is empty or being drained.
    out_free           = !out_valid || out_ready;
    // The last column is always emitted so the row-close beat is never lost.
    emit_entry         = !(SKIP_NULL && entry_null && !at_eor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_shift <= '0;
      out_null  <= 1'b0;
      out_eor   <= 1'b0;
      out_last  <= 1'b0;
    end else if (abort) begin
      // Cancel silently: no done pulse, err keeps whatever it has seen.
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg <= SCAN;
            row_reg   <= '0;
            col_reg   <= '0;
            rom_addr  <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            out_valid <= 1'b0;
          end
        end

        SCAN: begin
          // Under backpressure nothing moves: address, counters and payload hold.
          if (out_free) begin
            if (entry_illegal) begin
              err <= 1'b1;
            end

            if (emit_entry) begin
              out_valid <= 1'b1;
              out_row   <= row_reg;
              out_col   <= col_reg;
              out_shift <= entry_null ? '0 : rom_data;
              out_null  <= entry_null;
              out_eor   <= at_eor;
              out_last  <= at_end;
            end else begin
              // Entry consumed with no beat; any previous beat has just drained.
              out_valid <= 1'b0;
            end

            if (at_end) begin
              // The final entry is always emitted, so DRAIN owns a last beat.
              state_reg <= DRAIN;
            end else begin
              rom_addr <= rom_addr + AW'(1);
              if (at_eor) begin
                col_reg <= '0;
                row_reg <= row_reg + RW'(1);
              end else begin
                col_reg <= col_reg + CW'(1);
              end
            end
          end
        end

        DRAIN: begin
          if (done) begin
            // busy stays up through the done cycle and falls the cycle after.
            done      <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            rom_addr  <= '0;
          end else if (out_valid && out_ready && out_last) begin
            done      <= 1'b1;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proto_matrix_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proto_matrix_sequencer
//
// Runs two sequencers side by side on the same ROM image: one emits every
// entry and the other drops null blocks. A reference model builds the
// expected beat list for each of them directly from the ROM contents. Every
// handshake is compared against that list, and held payloads are checked
// across stalls. Done and busy timing, err behaviour, abort and reset are
// also checked.
// -----------------------------------------------------------------------------
module tb_proto_matrix_sequencer;

  localparam int Z      = 54;
  localparam int ROWS   = 4;
  localparam int COLS   = 24;
  localparam int SHIFTW = 6;
  localparam int AW     = 7;
  localparam int N      = ROWS * COLS;
  localparam int MAXCYC = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  logic [SHIFTW-1:0] rom [128];

  logic              busy      [2];
  logic              done      [2];
  logic              err       [2];
  logic [AW-1:0]     rom_addr  [2];
  logic [SHIFTW-1:0] rom_data  [2];
  logic              out_valid [2];
  logic [1:0]        out_row   [2];
  logic [4:0]        out_col   [2];
  logic [SHIFTW-1:0] out_shift [2];
  logic              out_null  [2];
  logic              out_eor   [2];
  logic              out_last  [2];

  // Instance 0 emits every entry, instance 1 drops null blocks.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign rom_data[gi] = rom[rom_addr[gi]];
      proto_matrix_sequencer #(
        .Z(Z), .ROWS(ROWS), .COLS(COLS), .SHIFTW(SHIFTW), .SKIP_NULL(gi == 1)
      ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy[gi]), .done(done[gi]), .err(err[gi]),
        .rom_addr(rom_addr[gi]), .rom_data(rom_data[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready),
        .out_row(out_row[gi]), .out_col(out_col[gi]), .out_shift(out_shift[gi]),
        .out_null(out_null[gi]), .out_eor(out_eor[gi]), .out_last(out_last[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          exp_err;

  function automatic bit is_illegal(input logic [SHIFTW-1:0] d);
    return (int'(d) >= Z) && (d != 6'h3F);
  endfunction

  // Expected beat: {row, col, shift, null, eor, last}.
  task automatic build_model();
    q0.delete();
    q1.delete();
    exp_err = 1'b0;
    for (int a = 0; a < N; a++) begin
      int r = a / COLS;
      int c = a % COLS;
      logic [SHIFTW-1:0] d = rom[a];
      bit ill = is_illegal(d);
      bit nul = ill || (d == 6'h3F);
      logic [15:0] beat = {2'(r), 5'(c), (nul ? 6'd0 : d), nul, (c == COLS - 1), (a == N - 1)};
      if (ill) exp_err = 1'b1;
      q0.push_back(beat);
      if (!(nul && c != COLS - 1)) q1.push_back(beat);
    end
  endtask

  function automatic bit err_upto(input int lim);
    for (int a = 0; a < N && a <= lim; a++)
      if (is_illegal(rom[a])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] pk(input int i);
    return {out_row[i], out_col[i], out_shift[i], out_null[i], out_eor[i], out_last[i]};
  endfunction

  task automatic pop_cmp(input int i, input logic [15:0] got, input int n);
    logic [15:0] e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      check($sformatf("extra_beat[%0d] n=%0d", i, n), 1, 0);
    end else begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("beat[%0d] n=%0d", i, n), got, e);
    end
  endtask

  // ---------------------------------------------------------------- rom fills
  task automatic fill_mod();
    foreach (rom[a]) rom[a] = 6'(a % Z);
  endtask

  task automatic fill_odd_null();
    foreach (rom[a]) rom[a] = ((a % COLS) % 2 == 1) ? 6'h3F : 6'($urandom_range(0, Z - 1));
  endtask

  task automatic fill_err();
    foreach (rom[a]) rom[a] = 6'($urandom_range(0, Z - 1));
    rom[10] = 6'd60;
  endtask

  task automatic fill_rand();
    foreach (rom[a]) begin
      int k = $urandom_range(0, 9);
      if (k < 2)       rom[a] = 6'h3F;
      else if (k == 2) rom[a] = 6'($urandom_range(Z, 62));
      else             rom[a] = 6'($urandom_range(0, Z - 1));
    end
  endtask

  // ---------------------------------------------------------------- one scan
  task automatic run_scan(input string name, input int pct, input int abort_beat);
    int c;
    int beats[2];
    int done_cyc[2];
    int first_v[2];
    bit hs_last_prev[2];
    bit done_prev[2];
    bit stall_prev[2];
    bit fin[2];
    logic [22:0] saved[2];
    bit aborted;
    bit hs;

    build_model();
    for (int i = 0; i < 2; i++) begin
      beats[i] = 0; done_cyc[i] = -1; first_v[i] = -1;
      hs_last_prev[i] = 0; done_prev[i] = 0; stall_prev[i] = 0; fin[i] = 0;
      saved[i] = '0;
    end
    aborted = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s busy_c1[%0d]", name, i), busy[i], 1);
      check($sformatf("%s addr_c1[%0d]", name, i), rom_addr[i], 0);
      check($sformatf("%s err_clr[%0d]", name, i), err[i], 0);
    end

    while (!(fin[0] && fin[1]) && c < MAXCYC) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s done[%0d] c=%0d", name, i, c), done[i], hs_last_prev[i]);
        if (done_prev[i]) begin
          check($sformatf("%s busy_fall[%0d]", name, i), busy[i], 0);
          fin[i] = 1;
        end
        if (done[i]) begin
          check($sformatf("%s busy_at_done[%0d]", name, i), busy[i], 1);
          done_cyc[i] = c;
        end
        done_prev[i] = done[i];
        if (stall_prev[i])
          check($sformatf("%s hold[%0d] c=%0d", name, i, c), {pk(i), rom_addr[i]}, saved[i]);
        if (out_valid[i] && first_v[i] < 0) first_v[i] = c;
        if (pct == 100 && abort_beat < 0)
          check($sformatf("%s err_t[%0d] c=%0d", name, i, c), err[i], err_upto(c - 2));
      end

      // A start while busy must leave the scan untouched.
      start = (c == 20);
      if (abort_beat >= 0 && !aborted && beats[0] >= abort_beat) begin
        abort = 1'b1;
        out_ready = 1'b0;
        aborted = 1;
      end else begin
        abort = 1'b0;
        out_ready = ($urandom_range(0, 99) < pct);
      end

      for (int i = 0; i < 2; i++) begin
        hs = out_valid[i] && out_ready && !abort;
        if (hs) begin
          pop_cmp(i, pk(i), beats[i]);
          beats[i]++;
        end
        hs_last_prev[i] = hs && out_last[i];
        stall_prev[i]   = out_valid[i] && !out_ready && !abort;
        saved[i]        = {pk(i), rom_addr[i]};
      end

      tick();
      c++;

      if (aborted) begin
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
          check($sformatf("%s abort_valid[%0d]", name, i), out_valid[i], 0);
          check($sformatf("%s abort_busy[%0d]", name, i), busy[i], 0);
          check($sformatf("%s abort_addr[%0d]", name, i), rom_addr[i], 0);
          check($sformatf("%s abort_err_held[%0d]", name, i), err[i], 1);
        end
        for (int k = 0; k < 4; k++) begin
          for (int i = 0; i < 2; i++)
            check($sformatf("%s abort_nodone[%0d]", name, i), done[i], 0);
          tick();
        end
        $display("scan %s: aborted at beat %0d, cycle %0d", name, beats[0], c);
        return;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;

    if (c >= MAXCYC) check($sformatf("%s timeout", name), 0, 1);
    check($sformatf("%s leftover[0]", name), q0.size(), 0);
    check($sformatf("%s leftover[1]", name), q1.size(), 0);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s err_end[%0d]", name, i), err[i], exp_err);
    if (pct == 100) begin
      check($sformatf("%s first_beat_cyc", name), first_v[0], 2);
      check($sformatf("%s done_cyc", name), done_cyc[0], 98);
    end
    $display("scan %s: beats %0d/%0d, done at cycle %0d/%0d", name, beats[0], beats[1],
             done_cyc[0], done_cyc[1]);
  endtask

  // ---------------------------------------------------------------- reset mid-scan
  task automatic reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    repeat (39) tick();
    for (int i = 0; i < 2; i++)
      check($sformatf("pre_reset_err[%0d]", i), err[i], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_busy[%0d]", i), busy[i], 0);
      check($sformatf("rst_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("rst_addr[%0d]", i), rom_addr[i], 0);
      check($sformatf("rst_err[%0d]", i), err[i], 0);
      check($sformatf("rst_done[%0d]", i), done[i], 0);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    $display("reset asserted mid-scan at cycle 40");
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    foreach (rom[a]) rom[a] = '0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("init_busy[%0d]", i), busy[i], 0);
      check($sformatf("init_done[%0d]", i), done[i], 0);
      check($sformatf("init_err[%0d]", i), err[i], 0);
      check($sformatf("init_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("init_addr[%0d]", i), rom_addr[i], 0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    fill_mod();
    run_scan("mod_full", 100, -1);
    run_scan("mod_r30", 30, -1);

    fill_odd_null();
    run_scan("oddnull_full", 100, -1);
    run_scan("oddnull_r30", 30, -1);

    fill_err();
    run_scan("err_full", 100, -1);
    run_scan("err_r30", 30, -1);

    fill_rand();
    run_scan("rand_r30", 30, -1);
    rom[3] = 6'd60;
    run_scan("abort_r30", 30, 50);
    run_scan("after_abort_r50", 50, -1);

    fill_err();
    reset_mid();
    run_scan("after_reset_full", 100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
